// File: rtl/mmc3_irq_mapper.sv
// MMC3-style mapper: bank registers, PRG/CHR/WRAM/nametable address translation
// and the A12-clocked scanline IRQ counter with a low-time filter on A12.
module mmc3_irq_mapper #(
    parameter int PRG_BANK_W  = 6,
    parameter int CHR_BANK_W  = 8,
    parameter int EXT_AW      = 25,
    parameter int A12_LOW_MIN = 8
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  cpu_clock,
    input  logic [PRG_BANK_W-1:0] prg_last,
    input  logic [15:0]           cpu_bus,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    input  logic [13:0]           ppu_bus,
    input  logic                  ppu_wr,
    input  logic [7:0]            ppu_data_in,
    output logic [7:0]            ppu_data_out,
    output logic [EXT_AW-1:0]     ext_cpu_bus,
    input  logic [7:0]            ext_cpu_data_in,
    output logic [7:0]            ext_cpu_data_out,
    output logic                  ext_cpu_wr,
    output logic [EXT_AW-1:0]     ext_ppu_bus,
    input  logic [7:0]            ext_ppu_data_in,
    output logic [7:0]            ext_ppu_data_out,
    output logic                  ext_ppu_wr,
    output logic                  mirror,
    output logic                  irq_n
);

    localparam int CNT_W = $clog2(A12_LOW_MIN + 1);
    localparam logic [EXT_AW-1:0] EXT_BASE = EXT_AW'(32'h0010_0000);

    logic [7:0]       r_q [8];
    logic [7:0]       r_d [8];
    logic [2:0]       bank_sel_q, bank_sel_d;
    logic             prg_mode_q, prg_mode_d;
    logic             chr_inv_q, chr_inv_d;
    logic             mirror_q, mirror_d;
    logic             ram_en_q, ram_en_d;
    logic             ram_wp_q, ram_wp_d;
    logic [7:0]       irq_latch_q, irq_latch_d;
    logic [7:0]       irq_count_q, irq_count_d;
    logic             reload_q, reload_d;
    logic             irq_en_q, irq_en_d;
    logic             pending_q, pending_d;
    logic             a12_q, a12_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

    logic       wr_stb;
    logic [2:0] reg_sel;
    logic       a12_event;
    logic       irq_set;

    assign wr_stb    = cpu_clock & cpu_wr & cpu_bus[15];
    assign reg_sel   = {cpu_bus[14:13], cpu_bus[0]};
    assign a12_event = ppu_bus[12] & ~a12_q & (low_cnt_q >= CNT_W'(A12_LOW_MIN));

    always_comb begin
        r_d         = r_q;
        bank_sel_d  = bank_sel_q;
        prg_mode_d  = prg_mode_q;
        chr_inv_d   = chr_inv_q;
        mirror_d    = mirror_q;
        ram_en_d    = ram_en_q;
        ram_wp_d    = ram_wp_q;
        irq_latch_d = irq_latch_q;
        irq_count_d = irq_count_q;
        reload_d    = reload_q;
        irq_en_d    = irq_en_q;
        irq_set     = 1'b0;

        if (wr_stb) begin
            case (reg_sel)
                3'b000: begin
                    bank_sel_d = cpu_data_in[2:0];
                    prg_mode_d = cpu_data_in[6];
                    chr_inv_d  = cpu_data_in[7];
                end
                3'b001:  r_d[bank_sel_q] = cpu_data_in;
                3'b010:  mirror_d = cpu_data_in[0];
                3'b011: begin
                    ram_en_d = cpu_data_in[7];
                    ram_wp_d = cpu_data_in[6];
                end
                3'b100:  irq_latch_d = cpu_data_in;
                3'b110:  irq_en_d = 1'b0;
                3'b111:  irq_en_d = 1'b1;
                default: ;
            endcase
        end

        // A $C001 write overrides a coincident A12 clock event entirely
        if (wr_stb && reg_sel == 3'b101) begin
            irq_count_d = 8'd0;
            reload_d    = 1'b1;
        end else if (a12_event) begin
            if (irq_count_q == 8'd0 || reload_q) begin
                irq_count_d = irq_latch_q;
                reload_d    = 1'b0;
            end else begin
                irq_count_d = irq_count_q - 8'd1;
            end
            irq_set = (irq_count_d == 8'd0) && irq_en_q;
        end

        if (wr_stb && reg_sel == 3'b110) pending_d = 1'b0;
        else                             pending_d = pending_q | irq_set;

        a12_d = ppu_bus[12];
        if (ppu_bus[12])                                 low_cnt_d = '0;
        else if (low_cnt_q == CNT_W'(A12_LOW_MIN))       low_cnt_d = low_cnt_q;
        else                                             low_cnt_d = low_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) r_q[i] <= '0;
            bank_sel_q  <= '0;
            prg_mode_q  <= 1'b0;
            chr_inv_q   <= 1'b0;
            mirror_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_wp_q    <= 1'b0;
            irq_latch_q <= '0;
            irq_count_q <= '0;
            reload_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            pending_q   <= 1'b0;
            a12_q       <= 1'b0;
            low_cnt_q   <= '0;
        end else begin
            r_q         <= r_d;
            bank_sel_q  <= bank_sel_d;
            prg_mode_q  <= prg_mode_d;
            chr_inv_q   <= chr_inv_d;
            mirror_q    <= mirror_d;
            ram_en_q    <= ram_en_d;
            ram_wp_q    <= ram_wp_d;
            irq_latch_q <= irq_latch_d;
            irq_count_q <= irq_count_d;
            reload_q    <= reload_d;
            irq_en_q    <= irq_en_d;
            pending_q   <= pending_d;
            a12_q       <= a12_d;
            low_cnt_q   <= low_cnt_d;
        end
    end

    assign mirror = mirror_q;
    assign irq_n  = ~pending_q;

    logic [PRG_BANK_W-1:0] prg_bank;
    logic [PRG_BANK_W-1:0] prg_last_m1;
    assign prg_last_m1 = prg_last - PRG_BANK_W'(1);

    always_comb begin
        case (cpu_bus[14:13])
            2'b00:   prg_bank = prg_mode_q ? prg_last_m1 : PRG_BANK_W'(r_q[6]);
            2'b01:   prg_bank = PRG_BANK_W'(r_q[7]);
            2'b10:   prg_bank = prg_mode_q ? PRG_BANK_W'(r_q[6]) : prg_last_m1;
            default: prg_bank = prg_last;
        endcase
        prg_bank = prg_bank & prg_last;

        ext_cpu_data_out = cpu_data_in;
        if (cpu_bus[15]) begin
            ext_cpu_bus  = EXT_AW'({prg_bank, cpu_bus[12:0]});
            ext_cpu_wr   = 1'b0;
            cpu_data_out = ext_cpu_data_in;
        end else if (cpu_bus[14:13] == 2'b11) begin
            ext_cpu_bus  = EXT_BASE | EXT_AW'({2'b11, cpu_bus[12:0]});
            ext_cpu_wr   = cpu_wr & ram_en_q & ~ram_wp_q;
            cpu_data_out = ram_en_q ? ext_cpu_data_in : 8'hFF;
        end else begin
            ext_cpu_bus  = EXT_BASE | EXT_AW'(cpu_bus[14:0]);
            ext_cpu_wr   = cpu_wr;
            cpu_data_out = ext_cpu_data_in;
        end
    end

    logic       chr_p;
    logic [7:0] chr_bank;
    assign chr_p = ppu_bus[12] ^ chr_inv_q;

    always_comb begin
        // 2 KB mode forces bit0 of R0/R1 to come from A10
        if (!chr_p)
            chr_bank = (r_q[{2'b00, ppu_bus[11]}] & 8'hFE) | {7'b0, ppu_bus[10]};
        else
            chr_bank = r_q[3'd2 + {1'b0, ppu_bus[11:10]}];

        if (ppu_bus[13])
            ext_ppu_bus = EXT_BASE | EXT_AW'({(mirror_q ? ppu_bus[11] : ppu_bus[10]), ppu_bus[9:0]});
        else
            ext_ppu_bus = EXT_AW'({CHR_BANK_W'(chr_bank), ppu_bus[9:0]});
    end

    assign ppu_data_out     = ext_ppu_data_in;
    assign ext_ppu_data_out = ppu_data_in;
    assign ext_ppu_wr       = ppu_wr;

endmodule

// File: tb/tb_mmc3_irq_mapper.sv
// Scoreboard bench for mmc3_irq_mapper: expectations are queued as stimulus is
// applied and popped when the corresponding output is sampled.
module tb_mmc3_irq_mapper;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_clock = 1'b0;
    logic [5:0]  prg_last = 6'd15;
    logic [15:0] cpu_bus = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_data_in = '0;
    logic [7:0]  cpu_data_out;
    logic [13:0] ppu_bus = '0;
    logic        ppu_wr = 1'b0;
    logic [7:0]  ppu_data_in = '0;
    logic [7:0]  ppu_data_out;
    logic [24:0] ext_cpu_bus;
    logic [7:0]  ext_cpu_data_in = '0;
    logic [7:0]  ext_cpu_data_out;
    logic        ext_cpu_wr;
    logic [24:0] ext_ppu_bus;
    logic [7:0]  ext_ppu_data_in = '0;
    logic [7:0]  ext_ppu_data_out;
    logic        ext_ppu_wr;
    logic        mirror;
    logic        irq_n;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q [$];

    mmc3_irq_mapper dut (
        .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .prg_last(prg_last),
        .cpu_bus(cpu_bus), .cpu_wr(cpu_wr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .ppu_bus(ppu_bus), .ppu_wr(ppu_wr), .ppu_data_in(ppu_data_in), .ppu_data_out(ppu_data_out),
        .ext_cpu_bus(ext_cpu_bus), .ext_cpu_data_in(ext_cpu_data_in),
        .ext_cpu_data_out(ext_cpu_data_out), .ext_cpu_wr(ext_cpu_wr),
        .ext_ppu_bus(ext_ppu_bus), .ext_ppu_data_in(ext_ppu_data_in),
        .ext_ppu_data_out(ext_ppu_data_out), .ext_ppu_wr(ext_ppu_wr),
        .mirror(mirror), .irq_n(irq_n)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge sysclk);
        cpu_bus = a; cpu_data_in = d; cpu_wr = 1'b1; cpu_clock = 1'b1;
        @(negedge sysclk);
        cpu_wr = 1'b0; cpu_clock = 1'b0; cpu_bus = 16'h0000;
    endtask

    task automatic a12_pulse(input int low, input int high);
        @(negedge sysclk);
        ppu_bus = 14'h0000;
        repeat (low) @(negedge sysclk);
        ppu_bus = 14'h1000;
        repeat (high) @(negedge sysclk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b0;
        prg_last = 6'd15;
        // attempted register write while in reset must be ignored
        @(negedge sysclk);
        cpu_bus = 16'hA000; cpu_data_in = 8'h01; cpu_wr = 1'b1; cpu_clock = 1'b1;
        @(negedge sysclk);
        cpu_wr = 1'b0; cpu_clock = 1'b0; cpu_bus = 16'h8000; ppu_bus = 14'h0000;
        sb_q.push_back(32'h1); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        #2;
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL reset_irq_n: got %b expected %b", irq_n, e[0]); end
        e = sb_q.pop_front(); checks++;
        if (mirror !== e[0]) begin errors++; $display("FAIL reset_mirror: got %b expected %b", mirror, e[0]); end
        e = sb_q.pop_front(); checks++;
        if (32'(ext_cpu_bus) !== e) begin errors++; $display("FAIL reset_prg8000: got %h expected %h", ext_cpu_bus, e); end
        e = sb_q.pop_front(); checks++;
        if (32'(ext_ppu_bus) !== e) begin errors++; $display("FAIL reset_chr0: got %h expected %h", ext_ppu_bus, e); end
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    task automatic test_prg();
        logic [15:0] addr [7];
        logic [31:0] expv [7];
        logic [31:0] e;
        addr[0] = 16'h8000; expv[0] = 32'h06000;
        addr[1] = 16'hE000; expv[1] = 32'h1E000;
        addr[2] = 16'hC000; expv[2] = 32'h06000;
        addr[3] = 16'h8000; expv[3] = 32'h1C000;
        addr[4] = 16'hE123; expv[4] = 32'h1E123;
        addr[5] = 16'h8000; expv[5] = 32'h06000;
        addr[6] = 16'h9234; expv[6] = 32'h07234;
        cpu_write(16'h8000, 8'h06);
        cpu_write(16'h8001, 8'h03);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) cpu_write(16'h8000, 8'h46);
            if (i == 5) begin
                cpu_write(16'h8000, 8'h06);
                cpu_write(16'h8001, 8'h13);
            end
            @(negedge sysclk);
            cpu_bus = addr[i];
            sb_q.push_back(expv[i]);
            #2;
            e = sb_q.pop_front(); checks++;
            if (32'(ext_cpu_bus) !== e)
                begin errors++; $display("FAIL prg_map[%0d] addr %h: got %h expected %h", i, addr[i], ext_cpu_bus, e); end
        end
        ext_cpu_data_in = 8'hA5;
        sb_q.push_back(32'hA5);
        #1;
        e = sb_q.pop_front(); checks++;
        if (32'(cpu_data_out) !== e) begin errors++; $display("FAIL prg_rdata: got %h expected %h", cpu_data_out, e); end
    endtask

    task automatic test_chr();
        logic [13:0] addr [4];
        logic [31:0] expv [4];
        logic [31:0] e;
        cpu_write(16'h8000, 8'h82);
        cpu_write(16'h8001, 8'h21);
        cpu_write(16'h8000, 8'h80);
        cpu_write(16'h8001, 8'h0B);
        addr[0] = 14'h0000; expv[0] = 32'h08400;
        addr[1] = 14'h1523; expv[1] = 32'h02D23;
        addr[2] = 14'h1123; expv[2] = 32'h02923;
        addr[3] = 14'h2400; expv[3] = 32'h100400;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            ppu_bus = addr[i];
            sb_q.push_back(expv[i]);
            #2;
            e = sb_q.pop_front(); checks++;
            if (32'(ext_ppu_bus) !== e)
                begin errors++; $display("FAIL chr_map[%0d] addr %h: got %h expected %h", i, addr[i], ext_ppu_bus, e); end
        end
        cpu_write(16'hA000, 8'h01);
        addr[0] = 14'h2400; expv[0] = 32'h100000;
        addr[1] = 14'h2800; expv[1] = 32'h100400;
        for (int i = 0; i < 2; i++) begin
            @(negedge sysclk);
            ppu_bus = addr[i];
            sb_q.push_back(expv[i]);
            #2;
            e = sb_q.pop_front(); checks++;
            if (32'(ext_ppu_bus) !== e)
                begin errors++; $display("FAIL nt_map[%0d] addr %h: got %h expected %h", i, addr[i], ext_ppu_bus, e); end
        end
        sb_q.push_back(32'h1);
        e = sb_q.pop_front(); checks++;
        if (mirror !== e[0]) begin errors++; $display("FAIL mirror_out: got %b expected %b", mirror, e[0]); end
        ext_ppu_data_in = 8'h3C; ppu_wr = 1'b1; ppu_data_in = 8'hC3;
        sb_q.push_back({22'h0, 1'b1, 8'h3C, 1'b0});
        #1;
        e = sb_q.pop_front(); checks++;
        if ({22'h0, ext_ppu_wr, ppu_data_out, 1'b0} !== e || ext_ppu_data_out !== 8'hC3)
            begin errors++; $display("FAIL ppu_pass: got wr %b rd %h wd %h expected wr 1 rd 3c wd c3", ext_ppu_wr, ppu_data_out, ext_ppu_data_out); end
        ppu_wr = 1'b0;
        ppu_bus = 14'h0000;
    endtask

    task automatic test_wram();
        logic [31:0] e;
        cpu_write(16'hA001, 8'hC0);
        @(negedge sysclk);
        cpu_bus = 16'h6000; cpu_wr = 1'b1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h106000);
        #2;
        e = sb_q.pop_front(); checks++;
        if (ext_cpu_wr !== e[0]) begin errors++; $display("FAIL wram_wp_wr: got %b expected %b", ext_cpu_wr, e[0]); end
        e = sb_q.pop_front(); checks++;
        if (32'(ext_cpu_bus) !== e) begin errors++; $display("FAIL wram_addr: got %h expected %h", ext_cpu_bus, e); end
        cpu_wr = 1'b0;
        cpu_write(16'hA001, 8'h80);
        @(negedge sysclk);
        cpu_bus = 16'h6000; cpu_wr = 1'b1; ext_cpu_data_in = 8'h5A;
        sb_q.push_back(32'h1); sb_q.push_back(32'h5A);
        #2;
        e = sb_q.pop_front(); checks++;
        if (ext_cpu_wr !== e[0]) begin errors++; $display("FAIL wram_en_wr: got %b expected %b", ext_cpu_wr, e[0]); end
        e = sb_q.pop_front(); checks++;
        if (32'(cpu_data_out) !== e) begin errors++; $display("FAIL wram_rdata: got %h expected %h", cpu_data_out, e); end
        cpu_wr = 1'b0;
        cpu_write(16'hA001, 8'h00);
        @(negedge sysclk);
        cpu_bus = 16'h6000;
        sb_q.push_back(32'hFF);
        #2;
        e = sb_q.pop_front(); checks++;
        if (32'(cpu_data_out) !== e) begin errors++; $display("FAIL wram_off_rdata: got %h expected %h", cpu_data_out, e); end
        @(negedge sysclk);
        cpu_bus = 16'h2002; cpu_wr = 1'b1;
        sb_q.push_back(32'h102002); sb_q.push_back(32'h1);
        #2;
        e = sb_q.pop_front(); checks++;
        if (32'(ext_cpu_bus) !== e) begin errors++; $display("FAIL low_addr: got %h expected %h", ext_cpu_bus, e); end
        e = sb_q.pop_front(); checks++;
        if (ext_cpu_wr !== e[0]) begin errors++; $display("FAIL low_wr: got %b expected %b", ext_cpu_wr, e[0]); end
        cpu_bus = 16'h8000;
        sb_q.push_back(32'h0);
        #1;
        e = sb_q.pop_front(); checks++;
        if (ext_cpu_wr !== e[0]) begin errors++; $display("FAIL rom_wr: got %b expected %b", ext_cpu_wr, e[0]); end
        cpu_wr = 1'b0;
        cpu_bus = 16'h0000;
    endtask

    task automatic test_irq();
        logic [31:0] e;
        ppu_bus = 14'h0000;
        cpu_write(16'hC000, 8'h02);
        cpu_write(16'hC001, 8'h00);
        cpu_write(16'hE001, 8'h00);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back((i == 2) ? 32'h0 : 32'h1);
            a12_pulse(10, 4);
            e = sb_q.pop_front(); checks++;
            if (irq_n !== e[0]) begin errors++; $display("FAIL irq_edge[%0d]: got %b expected %b", i, irq_n, e[0]); end
        end
        sb_q.push_back(32'h1);
        cpu_write(16'hE000, 8'h00);
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL irq_ack: got %b expected %b", irq_n, e[0]); end
    endtask

    task automatic test_filter();
        logic [31:0] e;
        cpu_write(16'hC000, 8'h00);
        cpu_write(16'hC001, 8'h00);
        cpu_write(16'hE001, 8'h00);
        sb_q.push_back(32'h1);
        a12_pulse(4, 4);
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL filter_short: got %b expected %b", irq_n, e[0]); end
        sb_q.push_back(32'h0);
        a12_pulse(10, 4);
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL latch0_irq: got %b expected %b", irq_n, e[0]); end
        cpu_write(16'hE000, 8'h00);
        sb_q.push_back(32'h1);
        a12_pulse(10, 4);
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL irq_disabled: got %b expected %b", irq_n, e[0]); end
        cpu_write(16'hE001, 8'h00);
        sb_q.push_back(32'h0);
        a12_pulse(10, 4);
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL latch0_again: got %b expected %b", irq_n, e[0]); end
        cpu_write(16'hE000, 8'h00);

        // $C001 landing on a valid edge: counter must restart from a reload
        cpu_write(16'hC000, 8'h02);
        cpu_write(16'hE001, 8'h00);
        @(negedge sysclk);
        ppu_bus = 14'h0000;
        repeat (10) @(negedge sysclk);
        ppu_bus = 14'h1000;
        cpu_bus = 16'hC001; cpu_wr = 1'b1; cpu_clock = 1'b1;
        @(negedge sysclk);
        cpu_wr = 1'b0; cpu_clock = 1'b0; cpu_bus = 16'h0000;
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back((i == 2) ? 32'h0 : 32'h1);
            a12_pulse(10, 4);
            e = sb_q.pop_front(); checks++;
            if (irq_n !== e[0]) begin errors++; $display("FAIL c001_race_edge[%0d]: got %b expected %b", i, irq_n, e[0]); end
        end
        cpu_write(16'hE000, 8'h00);

        // $E000 landing on a counting edge that would set pending
        cpu_write(16'hC000, 8'h00);
        cpu_write(16'hC001, 8'h00);
        cpu_write(16'hE001, 8'h00);
        @(negedge sysclk);
        ppu_bus = 14'h0000;
        repeat (10) @(negedge sysclk);
        ppu_bus = 14'h1000;
        cpu_bus = 16'hE000; cpu_wr = 1'b1; cpu_clock = 1'b1;
        sb_q.push_back(32'h1);
        @(negedge sysclk);
        cpu_wr = 1'b0; cpu_clock = 1'b0; cpu_bus = 16'h0000;
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL e000_race: got %b expected %b", irq_n, e[0]); end
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        cpu_write(16'hA000, 8'h01);
        cpu_write(16'hC000, 8'h00);
        cpu_write(16'hE001, 8'h00);
        sb_q.push_back(32'h0);
        a12_pulse(10, 4);
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL pre_reset_irq: got %b expected %b", irq_n, e[0]); end
        @(posedge sysclk);
        #2;
        reset = 1'b0;
        sb_q.push_back(32'h1); sb_q.push_back(32'h0);
        #1;
        e = sb_q.pop_front(); checks++;
        if (irq_n !== e[0]) begin errors++; $display("FAIL async_rst_irq_n: got %b expected %b", irq_n, e[0]); end
        e = sb_q.pop_front(); checks++;
        if (mirror !== e[0]) begin errors++; $display("FAIL async_rst_mirror: got %b expected %b", mirror, e[0]); end
        @(negedge sysclk);
        reset = 1'b1;
        cpu_bus = 16'h8000;
        sb_q.push_back(32'h0);
        #2;
        e = sb_q.pop_front(); checks++;
        if (32'(ext_cpu_bus) !== e) begin errors++; $display("FAIL post_rst_r6: got %h expected %h", ext_cpu_bus, e); end
        cpu_bus = 16'h0000;
    endtask

    initial begin
        test_reset();
        test_prg();
        test_chr();
        test_wram();
        test_irq();
        test_filter();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmc3_irq_mapper.md
MMC3_IRQ_MAPPER -- requirements
Module: mmc3_irq_mapper

Interface
REQ-001 Parameters SHALL be: PRG_BANK_W, default 6, width of 8 KB PRG bank numbers; CHR_BANK_W, default 8, width of 1 KB CHR bank numbers; EXT_AW, default 25, external address width; A12_LOW_MIN, default 8, minimum sysclk cycles A12 must stay low before a rising edge counts.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
sysclk  in  1  system clock
reset  in  1  async active-low reset
cpu_clock  in  1  CPU cycle strobe; the mapper accepts register writes only when it is high
prg_last  in  PRG_BANK_W  index of the last 8 KB PRG bank (bank count minus 1; power-of-two size)
cpu_bus  in  16  CPU address
cpu_wr  in  1  CPU write
cpu_data_in  in  8  CPU write data
cpu_data_out  out  8  CPU read data
ppu_bus  in  14  PPU address
ppu_wr  in  1  PPU write
ppu_data_in  in  8  PPU write data
ppu_data_out  out  8  PPU read data
ext_cpu_bus  out  EXT_AW  external CPU-side address
ext_cpu_data_in  in  8  external CPU-side read data
ext_cpu_data_out  out  8  external CPU-side write data
ext_cpu_wr  out  1  external CPU-side write
ext_ppu_bus  out  EXT_AW  external PPU-side address
ext_ppu_data_in  in  8  external PPU-side read data
ext_ppu_data_out  out  8  external PPU-side write data
ext_ppu_wr  out  1  external PPU-side write
mirror  out  1  0 = vertical, 1 = horizontal
irq_n  out  1  active-low interrupt request

Function
REQ-004 Register write strobe SHALL be cpu_clock & cpu_wr & cpu_bus[15]; the register is selected by cpu_bus[14:13] and cpu_bus[0], and every write takes effect on that sysclk edge.
REQ-005 $8000 even: bank_sel <= data[2:0]; prg_mode <= data[6]; chr_inv <= data[7]. $8001 odd: R[bank_sel] <= data.
REQ-006 $A000 even: mirror <= data[0]. $A001 odd: ram_en <= data[7]; ram_wp <= data[6].
REQ-007 $C000 even: irq_latch <= data. $C001 odd: irq_count <= 0 and reload <= 1.
REQ-008 $E000 even: irq_en <= 0 and pending IRQ is cleared. $E001 odd: irq_en <= 1.
REQ-009 PRG windows (8 KB). $8000: R6 if prg_mode=0, else prg_last-1. $A000: R7. $C000: prg_last-1 if prg_mode=0, else R6. $E000: prg_last.
REQ-010 Each PRG bank number SHALL be ANDed with prg_last (wrap). ext_cpu_bus = zero-extended {bank, cpu_bus[12:0]}. ext_cpu_wr = 0 for cpu_bus[15]=1.
REQ-011 For $6000-$7FFF: ext_cpu_bus = 0x100000 | {2'b11, cpu_bus[12:0]}. ext_cpu_wr = cpu_wr & ram_en & ~ram_wp. cpu_data_out = 8'hFF when ram_en=0.
REQ-012 For cpu_bus < $6000: ext_cpu_bus = 0x100000 | cpu_bus[14:0], with cpu_wr passed through. All other CPU reads SHALL return ext_cpu_data_in combinationally.
REQ-013 CHR mapping (1 KB units) uses p = ppu_bus[12] ^ chr_inv. When p=0, 2 KB banks: R0 (bit0 cleared) for ppu_bus[11]=0, R1 (bit0 cleared) for ppu_bus[11]=1, with ppu_bus[10] as bank bit0. When p=1, 1 KB banks R2..R5 are selected by ppu_bus[11:10]. ext_ppu_bus = {bank, ppu_bus[9:0]}.
REQ-014 For ppu_bus[13]=1: ext_ppu_bus = 0x100000 | {ppu_bus[11] if mirror else ppu_bus[10], ppu_bus[9:0]}. PPU data and write SHALL pass through unchanged.
REQ-015 A12 filter: a low-run counter saturating at A12_LOW_MIN counts consecutive sysclk cycles with ppu_bus[12]=0. A clock event is a 0->1 transition of registered A12 when the run count >= A12_LOW_MIN. The low-run counter clears while A12=1.
REQ-016 On a clock event: if irq_count==0 or reload=1, then irq_count <= irq_latch and reload <= 0; else irq_count <= irq_count-1.
REQ-017 If the new irq_count == 0 and irq_en = 1, pending SHALL set. irq_n = ~pending. Pending holds until a $E000 write or reset.
REQ-018 Simultaneous events: a $C001 write SHALL win over a clock event in the same cycle. A $E000 write SHALL win over setting pending, so irq_n stays 1.
REQ-019 With irq_latch=0 and irq_en=1, every clock event SHALL assert the IRQ.

Reset
REQ-020 While reset is low, all registers SHALL be 0 and irq_n SHALL be 1; this includes R0-R7, bank_sel, prg_mode, chr_inv, mirror, ram_en, ram_wp, irq_latch, irq_count, reload, irq_en, pending, and the filter state.
REQ-021 Reset asserted mid-operation SHALL clear all state asynchronously, with no dependence on sysclk.

Verification
REQ-022 prg_last=15; write $8000=0x06, $8001=0x03; read $8000 -> ext_cpu_bus=0x06000; read $E000 -> 0x1E000; write $8000=0x46 -> $C000 maps to 0x06000 and $8000 maps to 0x1C000.
REQ-023 Write R6=0x13 with prg_last=15 -> bank wraps to 3.
REQ-024 Write $8000=0x80, R2=0x21; PPU read 0x0000 -> ext_ppu_bus=0x08400.
REQ-025 Latch=2, $C001, $E001; A12 pulses low 10 cycles each; the 1st edge loads 2, the 3rd edge gives irq_n=0; $E000 -> irq_n=1.
REQ-026 A12 low only 4 cycles (A12_LOW_MIN=8) -> no count; $C001 in the same cycle as a valid edge -> count stays 0 and reload stays 1.
REQ-027 $A001=0xC0 then a write to $6000 -> ext_cpu_wr=0; $A001=0x80 -> ext_cpu_wr=1; mid-test reset -> irq_n=1 and mirror=0 immediately.
